// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and memory freeze.
// Optional saturating stall-cycle counter enabled by defining STALL_COUNT_EN.
module hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemRead_EX,
    input  logic [4:0]       Rd_EX,
    input  logic [4:0]       Rn_ID,
    input  logic [4:0]       Rm_ID,
    input  logic             Rm_used_ID,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_hold,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned FC_W = 3;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        MEMWAIT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    state_e           ret_q, ret_d;
    state_e           eff_state;
    logic [FC_W-1:0]  cnt_q, cnt_d;
    logic             load_use;

    // Register 31 is XZR and never creates a dependency.
    assign load_use = MemRead_EX & (Rd_EX != 5'd31) &
                      ((Rd_EX == Rn_ID) | (Rm_used_ID & (Rd_EX == Rm_ID)));

    // The cycle that leaves MEMWAIT is decoded as the state it returns to.
    assign eff_state = (state_q == MEMWAIT && !mem_busy) ? ret_q : state_q;

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        cnt_d       = cnt_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;

        if (mem_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
            state_d    = MEMWAIT;
            if (state_q != MEMWAIT) ret_d = state_q;
        end else begin
            case (eff_state)
                RUN: begin
                    state_d = RUN;
                    if (branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = FLUSH;
                            cnt_d   = FC_W'(FLUSH_CYCLES - 2);
                        end
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                FLUSH: begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        state_d = FLUSH;
                        cnt_d   = cnt_q - FC_W'(1);
                    end
                end
                default: state_d = RUN;
            endcase
        end

        // Reset forces a frozen, fetch-disabled pipeline.
        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
            pipe_hold   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            ret_q   <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state = state_q;

`ifdef STALL_COUNT_EN
    logic [CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (!pc_write && stall_q != '1) stall_d = stall_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_q <= '0;
        else       stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboarded directed test of hazard_ctrl; instance 0 uses FLUSH_CYCLES=2,
// instance 1 uses FLUSH_CYCLES=3.
module tb_hazard_ctrl;

    typedef struct {
        int          sel;
        logic [22:0] exp;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mr   [2];
    logic [4:0]  rd   [2];
    logic [4:0]  rn   [2];
    logic [4:0]  rm   [2];
    logic        rmu  [2];
    logic        bt   [2];
    logic        mb   [2];
    logic        pcw  [2];
    logic        ifw  [2];
    logic        ifl  [2];
    logic        bub  [2];
    logic        hold [2];
    logic [1:0]  st   [2];
    logic [15:0] sc   [2];

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   exp_stall [2];
    logic done = 1'b0;

    always #5 clk = ~clk;

    hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut2 (
        .clk(clk), .reset(reset), .MemRead_EX(mr[0]), .Rd_EX(rd[0]),
        .Rn_ID(rn[0]), .Rm_ID(rm[0]), .Rm_used_ID(rmu[0]),
        .branch_taken(bt[0]), .mem_busy(mb[0]), .pc_write(pcw[0]),
        .ifid_write(ifw[0]), .ifid_flush(ifl[0]), .idex_bubble(bub[0]),
        .pipe_hold(hold[0]), .state(st[0]), .stall_cycles(sc[0])
    );

    hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(16)) dut3 (
        .clk(clk), .reset(reset), .MemRead_EX(mr[1]), .Rd_EX(rd[1]),
        .Rn_ID(rn[1]), .Rm_ID(rm[1]), .Rm_used_ID(rmu[1]),
        .branch_taken(bt[1]), .mem_busy(mb[1]), .pc_write(pcw[1]),
        .ifid_write(ifw[1]), .ifid_flush(ifl[1]), .idex_bubble(bub[1]),
        .pipe_hold(hold[1]), .state(st[1]), .stall_cycles(sc[1])
    );

    // One cycle: drive inputs of the selected instance, idle the other, queue expectation.
    // e = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold}
    task automatic cyc(input string name, input int sel, input logic rst,
                       input logic m, input logic [4:0] d, input logic [4:0] n,
                       input logic [4:0] r, input logic ru, input logic b,
                       input logic busy, input logic [4:0] e, input logic [1:0] est);
        exp_t x;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            mr[i] = 1'b0; rd[i] = 5'd0; rn[i] = 5'd1; rm[i] = 5'd2;
            rmu[i] = 1'b0; bt[i] = 1'b0; mb[i] = 1'b0;
        end
        mr[sel] = m; rd[sel] = d; rn[sel] = n; rm[sel] = r;
        rmu[sel] = ru; bt[sel] = b; mb[sel] = busy;
        reset = rst;
        if (rst) begin
            exp_stall[0] = 0;
            exp_stall[1] = 0;
        end
        x.sel  = sel;
        x.name = name;
        x.exp  = {e, est, 16'(exp_stall[sel])};
        q.push_back(x);
`ifdef STALL_COUNT_EN
        if (!rst && !e[4]) exp_stall[sel]++;
`endif
    endtask

    // Monitor: outputs are combinational, so sample each cycle at the falling edge.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t x;
            logic [22:0] act;
            x   = q.pop_front();
            act = {pcw[x.sel], ifw[x.sel], ifl[x.sel], bub[x.sel], hold[x.sel],
                   st[x.sel], sc[x.sel]};
            n_cmp++;
            if (act !== x.exp) begin
                n_fail++;
                $display("FAIL %s: got pc/ifw/fl/bub/hold=%b state=%0d stall=%0d, want %b state=%0d stall=%0d",
                         x.name, act[22:18], act[17:16], act[15:0],
                         x.exp[22:18], x.exp[17:16], x.exp[15:0]);
            end
        end
    end

    localparam logic [4:0] DEF  = 5'b11000;
    localparam logic [4:0] LU   = 5'b00010;
    localparam logic [4:0] FL   = 5'b11110;
    localparam logic [4:0] HOLD = 5'b00001;
    localparam logic [4:0] RST  = 5'b00001;

    initial begin
        exp_stall[0] = 0;
        exp_stall[1] = 0;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mr[i] = 1'b0; rd[i] = 5'd0; rn[i] = 5'd1; rm[i] = 5'd2;
            rmu[i] = 1'b0; bt[i] = 1'b0; mb[i] = 1'b0;
        end
        //  name            sel rst mr rd     rn     rm     rmu bt mb  exp   st
        cyc("reset",         0, 1, 0, 5'd0,  5'd1,  5'd2,  0, 0, 0, RST,  2'd0);
        cyc("idle",          0, 0, 0, 5'd0,  5'd1,  5'd2,  0, 0, 0, DEF,  2'd0);
        cyc("lu_rn",         0, 0, 1, 5'd5,  5'd5,  5'd2,  0, 0, 0, LU,   2'd0);
        cyc("lu_after",      0, 0, 0, 5'd0,  5'd1,  5'd2,  0, 0, 0, DEF,  2'd0);
        cyc("xzr",           0, 0, 1, 5'd31, 5'd31, 5'd31, 1, 0, 0, DEF,  2'd0);
        cyc("rm_unused",     0, 0, 1, 5'd5,  5'd0,  5'd5,  0, 0, 0, DEF,  2'd0);
        cyc("rm_used",       0, 0, 1, 5'd5,  5'd0,  5'd5,  1, 0, 0, LU,   2'd0);
        cyc("not_load",      0, 0, 0, 5'd5,  5'd5,  5'd5,  1, 0, 0, DEF,  2'd0);
        cyc("br_c1",         0, 0, 0, 5'd0,  5'd1,  5'd2,  0, 1, 0, FL,   2'd0);
        cyc("br_c2",         0, 0, 0, 5'd0,  5'd1,  5'd2,  0, 0, 0, FL,   2'd1);
        cyc("br_done",       0, 0, 0, 5'd0,  5'd1,  5'd2,  0, 0, 0, DEF,  2'd0);
        cyc("br_lu_c1",      0, 0, 1, 5'd5,  5'd5,  5'd2,  0, 1, 0, FL,   2'd0);
        cyc("br_lu_c2",      0, 0, 1, 5'd5,  5'd5,  5'd2,  0, 0, 0, FL,   2'd1);
        cyc("br_lu_done",    0, 0, 0, 5'd0,  5'd1,  5'd2,  0, 0, 0, DEF,  2'd0);
        cyc("mb_run1",       0, 0, 0, 5'd0,  5'd1,  5'd2,  0, 0, 1, HOLD, 2'd0);
        cyc("mb_run2",       0, 0, 1, 5'd5,  5'd5,  5'd2,  0, 1, 1, HOLD, 2'd2);
        cyc("mb_run_ret",    0, 0, 0, 5'd0,  5'd1,  5'd2,  0, 0, 0, DEF,  2'd2);
        cyc("mb_run_after",  0, 0, 0, 5'd0,  5'd1,  5'd2,  0, 0, 0, DEF,  2'd0);
        cyc("mb_br_1",       0, 0, 0, 5'd0,  5'd1,  5'd2,  0, 1, 1, HOLD, 2'd0);
        cyc("mb_br_ret",     0, 0, 0, 5'd0,  5'd1,  5'd2,  0, 1, 0, FL,   2'd2);
        cyc("mb_br_fl2",     0, 0, 0, 5'd0,  5'd1,  5'd2,  0, 0, 0, FL,   2'd1);
        cyc("mb_br_done",    0, 0, 0, 5'd0,  5'd1,  5'd2,  0, 0, 0, DEF,  2'd0);
        cyc("f3_br",         1, 0, 0, 5'd0,  5'd1,  5'd2,  0, 1, 0, FL,   2'd0);
        cyc("f3_mb1",        1, 0, 1, 5'd5,  5'd5,  5'd2,  0, 0, 1, HOLD, 2'd1);
        cyc("f3_mb2",        1, 0, 0, 5'd0,  5'd1,  5'd2,  0, 0, 1, HOLD, 2'd2);
        cyc("f3_mb3",        1, 0, 0, 5'd0,  5'd1,  5'd2,  0, 0, 1, HOLD, 2'd2);
        cyc("f3_mb4",        1, 0, 0, 5'd0,  5'd1,  5'd2,  0, 0, 1, HOLD, 2'd2);
        cyc("f3_fl2",        1, 0, 0, 5'd0,  5'd1,  5'd2,  0, 0, 0, FL,   2'd2);
        cyc("f3_fl3",        1, 0, 1, 5'd5,  5'd5,  5'd2,  0, 0, 0, FL,   2'd1);
        cyc("f3_done",       1, 0, 0, 5'd0,  5'd1,  5'd2,  0, 0, 0, DEF,  2'd0);
        cyc("rst_mb1",       1, 0, 0, 5'd0,  5'd1,  5'd2,  0, 0, 1, HOLD, 2'd0);
        cyc("rst_mb2",       1, 0, 0, 5'd0,  5'd1,  5'd2,  0, 0, 1, HOLD, 2'd2);
        cyc("rst_in_wait",   1, 1, 0, 5'd0,  5'd1,  5'd2,  0, 0, 1, RST,  2'd0);
        cyc("rst_release",   1, 0, 0, 5'd0,  5'd1,  5'd2,  0, 0, 0, DEF,  2'd0);
        cyc("rst_other",     0, 0, 0, 5'd0,  5'd1,  5'd2,  0, 0, 0, DEF,  2'd0);
        @(posedge clk);
        @(posedge clk);
        done = 1'b1;
    end

    initial begin
        fork
            wait (done);
            #5000;
        join_any
        if (!done) begin
            n_fail++;
            $display("FAIL timeout: got no completion, want stimulus done");
        end
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, meaning the total number of cycles of flush per taken branch, including the detection cycle; legal range is 1..8.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the stall counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port MemRead_EX, input, 1 bit: the instruction in EX is a load.
REQ-006 SHALL have port Rd_EX, input, 5 bits: destination register of the EX instruction.
REQ-007 SHALL have ports Rn_ID and Rm_ID, input, 5 bits each: source registers of the ID instruction.
REQ-008 SHALL have port Rm_used_ID, input, 1 bit: Rm_ID is a real source operand.
REQ-009 SHALL have port branch_taken, input, 1 bit: a branch resolved taken this cycle.
REQ-010 SHALL have port mem_busy, input, 1 bit: data memory is not ready and the pipeline must freeze.
REQ-011 SHALL have port pc_write, output, 1 bit: PC load enable.
REQ-012 SHALL have port ifid_write, output, 1 bit: IF/ID load enable.
REQ-013 SHALL have port ifid_flush, output, 1 bit: clear IF/ID to NOP.
REQ-014 SHALL have port idex_bubble, output, 1 bit: zero all control bits entering ID/EX.
REQ-015 SHALL have port pipe_hold, output, 1 bit: hold ID/EX, EX/MEM and MEM/WB.
REQ-016 SHALL have port state, output, 2 bits: RUN=0, FLUSH=1, MEMWAIT=2.
REQ-017 SHALL have port stall_cycles, output, CNT_W bits: count of cycles with pc_write=0.

Function
REQ-018 SHALL define load_use = MemRead_EX & (Rd_EX!=31) & ((Rd_EX==Rn_ID) | (Rm_used_ID & Rd_EX==Rm_ID)), computed combinationally.
REQ-019 SHALL define the default output set as pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, pipe_hold=0.
REQ-020 SHALL apply event priority within a cycle in this order: mem_busy, then branch_taken, then load_use.
REQ-021 In RUN with mem_busy=1, SHALL drive pc_write=0, ifid_write=0, pipe_hold=1 and all other outputs at default, and SHALL go to MEMWAIT with ret_state=RUN.
REQ-022 In RUN with branch_taken=1, SHALL drive ifid_flush=1 and idex_bubble=1 in the same cycle; if FLUSH_CYCLES>1, SHALL go to FLUSH with cnt=FLUSH_CYCLES-2, otherwise SHALL stay in RUN.
REQ-023 In RUN with load_use=1 only, SHALL drive pc_write=0, ifid_write=0 and idex_bubble=1 for that cycle and SHALL stay in RUN, producing exactly one bubble per hazard.
REQ-024 In FLUSH, SHALL drive ifid_flush=1 and idex_bubble=1; when cnt=0 SHALL go to RUN, otherwise SHALL decrement cnt; load_use SHALL be ignored in this state.
REQ-025 In FLUSH with mem_busy=1, SHALL apply the MEMWAIT outputs, go to MEMWAIT with ret_state=FLUSH, and preserve cnt unchanged.
REQ-026 In MEMWAIT, SHALL apply the MEMWAIT outputs while mem_busy=1, and SHALL return to ret_state in the first cycle mem_busy=0, with that cycle decoded as ret_state.
REQ-027 SHALL ignore branch_taken in MEMWAIT, because the requester holds it until the freeze ends.
REQ-028 SHALL derive all outputs combinationally from the current state and inputs, with no added latency.

Reset
REQ-029 While reset is asserted, SHALL hold state=RUN, cnt=0, ret_state=RUN and stall_cycles=0 asynchronously.
REQ-030 While reset is asserted, SHALL hold pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=0 and pipe_hold=1.
REQ-031 On a reset asserted mid-FLUSH or mid-MEMWAIT, SHALL abandon the pending cnt and ret_state; the first cycle after release SHALL be RUN.

Configuration
REQ-032 With STALL_COUNT_EN defined, SHALL increment stall_cycles by 1 on every clock edge where pc_write=0 and reset=0, saturating at 2^CNT_W-1.
REQ-033 Without STALL_COUNT_EN, SHALL drive stall_cycles constant 0 with no counter flops.

Verification
REQ-034 SHALL verify load-use: MemRead_EX=1, Rd_EX=5, Rn_ID=5 for 1 cycle -> pc_write=0, ifid_write=0, idex_bubble=1 for 1 cycle only; state stays 0.
REQ-035 SHALL verify the XZR exemption: MemRead_EX=1, Rd_EX=31, Rn_ID=31 -> no stall; Rm_ID=5 with Rm_used_ID=0 and Rd_EX=5 -> no stall.
REQ-036 SHALL verify a taken branch with FLUSH_CYCLES=2: branch_taken pulse -> ifid_flush=1 for exactly 2 cycles, then state=0.
REQ-037 SHALL verify the simultaneous case: branch_taken=1 and load_use=1 in the same cycle -> flush taken, pc_write=1, no stall.
REQ-038 SHALL verify freeze mid-flush with FLUSH_CYCLES=3: mem_busy=1 for 4 cycles starting at flush cycle 2 -> 4 cycles with pipe_hold=1, then 2 remaining flush cycles; stall_cycles=4 with the macro defined, 0 without.
REQ-039 SHALL verify reset: assert reset during MEMWAIT -> state=0 immediately and stall_cycles=0; after release, outputs are at default.
